wcap_seq: RTL and testbench
===========================

Name: wcap_seq

Overview:
- Frame-capture sequencer in front of the wcoder pixel coder.
- Arms on a software start and synchronises to camera vsync/href.
- Counts pixels and lines, gates a programmable crop window into the coder (coder_href/coder_din), checks line/frame geometry and reports frame completion.
- All logic is in the pclk domain.

Parameters:
- H_PIX, 640, expected pixels per line (href-high pclk cycles)
- V_LINES, 480, expected lines per frame
- WIN_X0, 0, first captured pixel column
- WIN_W, 640, captured columns
- WIN_Y0, 0, first captured line
- WIN_H, 480, captured lines
- PW, 11, pixel counter width
- LW, 10, line counter width

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle pulse; arms capture of the next frame
- abort  in  1  one-cycle pulse; cancels capture
- vsync  in  1  camera frame sync, active-high
- href  in  1  camera line valid
- din  in  8  camera pixel byte
- coder_href  out  1  gated href to wcoder
- coder_din  out  8  registered pixel to wcoder
- busy  out  1  high in any state other than IDLE
- frame_done  out  1  one-cycle pulse at end of a good frame
- line_idx  out  LW  current line count
- pix_idx  out  PW  current pixel count within line
- err_len  out  1  sticky: line length or frame line-count mismatch
- err_sync  out  1  sticky: vsync rose mid-frame

Behaviour:
- Reset (async on rst_n low): state IDLE; all outputs 0; vsync_q=0; href_q=0.
- vsync_q/href_q register the previous vsync/href. Rising vsync = vsync & ~vsync_q. Falling href = ~href & href_q.
- IDLE:
  - start -> ARM.
  - start also clears err_len and err_sync.
- ARM: on rising vsync -> WAIT_LINE; line_idx=0.
- WAIT_LINE: on href=1 -> LINE; pix_idx=1 (the first pixel is counted on this edge).
- LINE:
  - pix_idx increments each cycle href=1, saturating at 2^PW-1.
  - On falling href:
    - If pix_idx != H_PIX, set err_len.
    - line_idx increments.
    - If the new line_idx == V_LINES -> DONE, else -> WAIT_LINE.
    - pix_idx resets to 0.
- DONE: frame_done=1 for exactly one cycle -> IDLE. frame_done is suppressed if err_len or err_sync is set.
- Rising vsync in WAIT_LINE or LINE:
  - Set err_sync.
  - Restart the frame: line_idx=0, pix_idx=0 -> WAIT_LINE.
  - A partial frame never produces frame_done.
- abort has priority over every other event: -> IDLE next edge, coder_href=0, counters cleared, error flags held.
- start outside IDLE is ignored.
- Window gating, with pixel column c = pix_idx before increment (0-based) and r = line_idx:
  - coder_href <= (state==LINE or entering LINE) & href & (WIN_X0 <= c < WIN_X0+WIN_W) & (WIN_Y0 <= r < WIN_Y0+WIN_H).
  - coder_din <= din every cycle.
  - Latency: exactly 1 pclk from href/din to coder_href/coder_din.
- Windows extending past H_PIX/V_LINES are clipped naturally.
- Window comparisons use PW/LW+1-bit arithmetic; no wrap.

Optional Feature:
- Macro: WCAP_FRAME_SKIP_EN.
- When defined:
  - Extra input skip [3:0].
  - ARM ignores skip rising-vsync edges before locking on the next one; skip=0 behaves as the baseline.
  - The skip count is sampled at start.
- When undefined: no skip port; ARM locks on the first rising vsync.

Test Plan:
- H_PIX=410, V_LINES=3, full window; start, vsync pulse, 3 lines of 410 pixels with din=pix+line+1 -> coder_href high for 410 cycles per line, coder_din lags din by 1, frame_done single pulse after the 3rd href fall, err flags 0.
- Same, but line 1 is 409 pixels -> err_len=1 after line 1, no frame_done, IDLE after line 3.
- WIN_X0=10, WIN_W=4, WIN_Y0=1, WIN_H=1 -> coder_href high only for line 1, columns 10..13, with coder_din=12..15.
- vsync pulse during line 2 -> err_sync=1, line_idx=0, next 3 good lines still give no frame_done.
- abort mid-line 1 -> busy=0 and coder_href=0 on the next edge; a new start clears err flags and captures normally.
- rst_n low mid-LINE, asynchronously -> all outputs 0 immediately; start without a subsequent vsync -> stays in ARM, busy=1.

Source files
------------

// File: rtl/wcap_if.sv
// Camera-side and coder-side signals of the wcap_seq frame-capture sequencer.
// Optional port: skip, present only when WCAP_FRAME_SKIP_EN is defined.
interface wcap_if #(
   parameter int PW = 11,
   parameter int LW = 10
) ();
   logic          start;
   logic          abort;
   logic          vsync;
   logic          href;
   logic [7:0]    din;
`ifdef WCAP_FRAME_SKIP_EN
   logic [3:0]    skip;
`endif
   logic          coder_href;
   logic [7:0]    coder_din;
   logic          busy;
   logic          frame_done;
   logic [LW-1:0] line_idx;
   logic [PW-1:0] pix_idx;
   logic          err_len;
   logic          err_sync;

   modport slave (
      input  start, abort, vsync, href, din,
`ifdef WCAP_FRAME_SKIP_EN
      input  skip,
`endif
      output coder_href, coder_din, busy, frame_done,
      output line_idx, pix_idx, err_len, err_sync
   );

   modport master (
      output start, abort, vsync, href, din,
`ifdef WCAP_FRAME_SKIP_EN
      output skip,
`endif
      input  coder_href, coder_din, busy, frame_done,
      input  line_idx, pix_idx, err_len, err_sync
   );
endinterface

// File: rtl/wcap_seq.sv
// Frame-capture sequencer in front of the wcoder pixel coder (pclk domain).
// Arms on start, locks on a rising vsync, counts pixels/lines, gates a crop
// window into the coder and flags line-length / frame-sync errors.
// Optional feature macro: WCAP_FRAME_SKIP_EN (skip N rising vsyncs in ARM).
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | not capturing; start arms the sequencer
// ARM       | waiting for the rising vsync that opens the frame
// WAIT_LINE | inside a frame, between lines (href low)
// LINE      | href high, counting pixels of the current line
// DONE      | one cycle after the last line; frame_done asserted here
module wcap_seq #(
   parameter int H_PIX   = 640,
   parameter int V_LINES = 480,
   parameter int WIN_X0  = 0,
   parameter int WIN_W   = 640,
   parameter int WIN_Y0  = 0,
   parameter int WIN_H   = 480,
   parameter int PW      = 11,
   parameter int LW      = 10
) (
   input logic   pclk,
   input logic   rst_n,
   wcap_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ARM, WAIT_LINE, LINE, DONE} state_t;

   localparam logic [PW:0]   X_LO    = (PW+1)'(WIN_X0);
   localparam logic [PW:0]   X_SZ    = (PW+1)'(WIN_W);
   localparam logic [LW:0]   Y_LO    = (LW+1)'(WIN_Y0);
   localparam logic [LW:0]   Y_SZ    = (LW+1)'(WIN_H);
   localparam logic [PW-1:0] H_LEN   = PW'(H_PIX);
   localparam logic [LW-1:0] V_CNT   = LW'(V_LINES);
   localparam logic [PW-1:0] PIX_MAX = '1;

   state_t        state, state_d;
   logic          vsync_q, href_q;
   logic [LW-1:0] line_q, line_d, line_inc;
   logic [PW-1:0] pix_q, pix_d;
   logic          err_len_q, err_len_d, err_sync_q, err_sync_d;
   logic          fd_q, fd_d, ch_q, ch_d;
   logic [7:0]    cdin_q;
   logic          vs_rise, href_fall, in_win;
   logic [PW+1:0] dx;
   logic [LW+1:0] dy;
`ifdef WCAP_FRAME_SKIP_EN
   logic [3:0]    skip_q, skip_d;
`endif

   assign vs_rise   = bus.vsync & ~vsync_q;
   assign href_fall = ~bus.href & href_q;
   assign line_inc  = line_q + LW'(1);

   // Offset from window origin with an explicit borrow bit: borrow set means
   // the pixel/line lies before the window, otherwise compare against size.
   assign dx     = {2'b00, pix_q} - {1'b0, X_LO};
   assign dy     = {2'b00, line_q} - {1'b0, Y_LO};
   assign in_win = ~dx[PW+1] & (dx[PW:0] < X_SZ) & ~dy[LW+1] & (dy[LW:0] < Y_SZ);

   // State, counters, sticky errors and the registered coder outputs.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         vsync_q    <= 1'b0;
         href_q     <= 1'b0;
         line_q     <= '0;
         pix_q      <= '0;
         err_len_q  <= 1'b0;
         err_sync_q <= 1'b0;
         fd_q       <= 1'b0;
         ch_q       <= 1'b0;
         cdin_q     <= '0;
`ifdef WCAP_FRAME_SKIP_EN
         skip_q     <= '0;
`endif
      end else begin
         state      <= state_d;
         vsync_q    <= bus.vsync;
         href_q     <= bus.href;
         line_q     <= line_d;
         pix_q      <= pix_d;
         err_len_q  <= err_len_d;
         err_sync_q <= err_sync_d;
         fd_q       <= fd_d;
         ch_q       <= ch_d;
         cdin_q     <= bus.din;
`ifdef WCAP_FRAME_SKIP_EN
         skip_q     <= skip_d;
`endif
      end
   end

   // Next-state, counter updates, error flags and window gating; abort wins.
   always_comb begin
      state_d    = state;
      line_d     = line_q;
      pix_d      = pix_q;
      err_len_d  = err_len_q;
      err_sync_d = err_sync_q;
      fd_d       = 1'b0;
`ifdef WCAP_FRAME_SKIP_EN
      skip_d     = skip_q;
`endif
      ch_d = bus.href & in_win & ((state == LINE) | ((state == WAIT_LINE) & ~vs_rise));
      if (bus.abort) begin
         state_d = IDLE;
         line_d  = '0;
         pix_d   = '0;
         ch_d    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state_d    = ARM;
                  err_len_d  = 1'b0;
                  err_sync_d = 1'b0;
`ifdef WCAP_FRAME_SKIP_EN
                  skip_d     = bus.skip;
`endif
               end
            end
            ARM: begin
               if (vs_rise) begin
`ifdef WCAP_FRAME_SKIP_EN
                  if (skip_q != 4'd0) begin
                     skip_d = skip_q - 4'd1;
                  end else begin
                     state_d = WAIT_LINE;
                     line_d  = '0;
                     pix_d   = '0;
                  end
`else
                  state_d = WAIT_LINE;
                  line_d  = '0;
                  pix_d   = '0;
`endif
               end
            end
            WAIT_LINE: begin
               if (vs_rise) begin
                  err_sync_d = 1'b1;
                  line_d     = '0;
                  pix_d      = '0;
               end else if (bus.href) begin
                  state_d = LINE;
                  pix_d   = PW'(1);
               end
            end
            LINE: begin
               if (vs_rise) begin
                  err_sync_d = 1'b1;
                  line_d     = '0;
                  pix_d      = '0;
                  state_d    = WAIT_LINE;
               end else if (href_fall) begin
                  if (pix_q != H_LEN) err_len_d = 1'b1;
                  line_d = line_inc;
                  pix_d  = '0;
                  if (line_inc == V_CNT) begin
                     state_d = DONE;
                     fd_d    = ~(err_len_d | err_sync_d);
                  end else begin
                     state_d = WAIT_LINE;
                  end
               end else if (bus.href && (pix_q != PIX_MAX)) begin
                  pix_d = pix_q + PW'(1);
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   assign bus.coder_href = ch_q;
   assign bus.coder_din  = cdin_q;
   assign bus.busy       = (state != IDLE);
   assign bus.frame_done = fd_q;
   assign bus.line_idx   = line_q;
   assign bus.pix_idx    = pix_q;
   assign bus.err_len    = err_len_q;
   assign bus.err_sync   = err_sync_q;
endmodule

// File: tb/tb_wcap_seq.sv
// Bench for wcap_seq: two instances (full window and a small crop window)
// share one camera stimulus; expectations come from frame-level bookkeeping.
module tb_wcap_seq;
   localparam int H = 410, V = 3, PWP = 11, LWP = 10;

   logic       pclk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0, abort = 1'b0, vsync = 1'b0, href = 1'b0;
   logic [7:0] din = 8'd0;

   wcap_if #(.PW(PWP), .LW(LWP)) ifa ();
   wcap_if #(.PW(PWP), .LW(LWP)) ifb ();

   assign ifa.start = start;  assign ifb.start = start;
   assign ifa.abort = abort;  assign ifb.abort = abort;
   assign ifa.vsync = vsync;  assign ifb.vsync = vsync;
   assign ifa.href  = href;   assign ifb.href  = href;
   assign ifa.din   = din;    assign ifb.din   = din;
`ifdef WCAP_FRAME_SKIP_EN
   assign ifa.skip  = 4'd0;   assign ifb.skip  = 4'd0;
`endif

   wcap_seq #(.H_PIX(H), .V_LINES(V), .WIN_X0(0), .WIN_W(H), .WIN_Y0(0), .WIN_H(V),
              .PW(PWP), .LW(LWP)) dut_a (.pclk(pclk), .rst_n(rst_n), .bus(ifa.slave));
   wcap_seq #(.H_PIX(H), .V_LINES(V), .WIN_X0(10), .WIN_W(4), .WIN_Y0(1), .WIN_H(1),
              .PW(PWP), .LW(LWP)) dut_b (.pclk(pclk), .rst_n(rst_n), .bus(ifb.slave));

   always #5 pclk = ~pclk;

   int vectors = 0, miscompares = 0;

   // frame-level model state
   bit m_busy = 0, m_el = 0, m_es = 0, m_fd = 0, m_cap = 0;
   int m_row = 0;

   // expectations for the current cycle
   bit         chk_en = 0;
   bit         e_ha, e_hb, e_busy, e_el, e_es, e_fd, e_idx;
   logic [7:0] e_din;
   int         e_line, e_pix;
   int         cnt_ha = 0, cnt_hb = 0, sum_b = 0, cnt_fd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit win_a(input int c, input int r);
      return (c < H) && (r < V);
   endfunction

   function automatic bit win_b(input int c, input int r);
      return (c >= 10) && (c < 14) && (r == 1);
   endfunction

   // per-cycle comparison of both instances against the expectations
   always @(negedge pclk) begin
      if (chk_en) begin
         chk("coder_href_a", ifa.coder_href, e_ha);
         chk("coder_href_b", ifb.coder_href, e_hb);
         chk("coder_din_a", ifa.coder_din, e_din);
         chk("coder_din_b", ifb.coder_din, e_din);
         chk("busy_a", ifa.busy, e_busy);
         chk("busy_b", ifb.busy, e_busy);
         chk("err_len_a", ifa.err_len, e_el);
         chk("err_len_b", ifb.err_len, e_el);
         chk("err_sync_a", ifa.err_sync, e_es);
         chk("frame_done_a", ifa.frame_done, e_fd);
         chk("frame_done_b", ifb.frame_done, e_fd);
         if (e_idx) begin
            chk("line_idx", ifa.line_idx, e_line);
            chk("pix_idx", ifa.pix_idx, e_pix);
         end
         cnt_ha += int'(ifa.coder_href);
         cnt_hb += int'(ifb.coder_href);
         if (ifb.coder_href) sum_b += int'(ifb.coder_din);
         cnt_fd += int'(ifa.frame_done);
      end
   end

   task automatic step(input bit vs, input bit hr, input bit st, input bit ab,
                       input logic [7:0] d, input bit eh_a, input bit eh_b, input int pix);
      vsync = vs; href = hr; start = st; abort = ab; din = d;
      @(posedge pclk);
      #1;
      e_ha = eh_a; e_hb = eh_b; e_din = d; e_busy = m_busy;
      e_el = m_el; e_es = m_es; e_fd = m_fd;
      e_idx = (pix >= 0); e_pix = pix; e_line = m_row;
      chk_en = 1;
   endtask

   task automatic idle(input int n, input bit stray);
      for (int i = 0; i < n; i++)
         step(0, 0, stray && ($urandom_range(0, 3) == 0), 0, 8'($urandom), 0, 0, -1);
   endtask

   task automatic do_start();
      m_busy = 1; m_el = 0; m_es = 0;
      step(0, 0, 1, 0, 8'($urandom), 0, 0, -1);
   endtask

   task automatic do_arm();
      m_cap = 1; m_row = 0;
      step(1, 0, 0, 0, 8'($urandom), 0, 0, -1);
      idle($urandom_range(1, 2), 1);
   endtask

   // kind 0: normal line; 1: vsync rises where href falls after cut pixels;
   // 2: abort on pixel cut, rest of the line still driven
   task automatic do_line(input int len, input int cut, input int kind, input bit det);
      int n;
      bit done;
      logic [7:0] d;
      idle($urandom_range(1, 3), m_busy);
      n = (kind == 0) ? len : cut;
      for (int c = 0; c < n; c++) begin
         d = det ? 8'(c + m_row + 1) : 8'($urandom);
         step(0, 1, 0, 0, d, m_cap && win_a(c, m_row), m_cap && win_b(c, m_row), m_cap ? c + 1 : -1);
      end
      if (kind == 2) begin
         m_busy = 0; m_cap = 0; m_row = 0;
         step(0, 1, 0, 1, 8'($urandom), 0, 0, -1);
         for (int c = n + 1; c < len; c++) step(0, 1, 0, 0, 8'($urandom), 0, 0, -1);
         step(0, 0, 0, 0, 8'($urandom), 0, 0, -1);
      end else if (kind == 1) begin
         m_es = 1; m_row = 0;
         step(1, 0, 0, 0, 8'($urandom), 0, 0, -1);
      end else begin
         done = 0;
         if (m_cap) begin
            if (len != H) m_el = 1;
            m_row++;
            done = (m_row == V);
            if (done) m_fd = !(m_el || m_es);
         end
         step(0, 0, 0, 0, 8'($urandom), 0, 0, -1);
         if (done) begin
            m_fd = 0; m_busy = 0; m_cap = 0;
            step(0, 0, 0, 0, 8'($urandom), 0, 0, -1);
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_coder_href"}, ifa.coder_href, 0);
      chk({tag, "_coder_din"}, ifa.coder_din, 0);
      chk({tag, "_busy"}, ifa.busy, 0);
      chk({tag, "_frame_done"}, ifa.frame_done, 0);
      chk({tag, "_line_idx"}, ifa.line_idx, 0);
      chk({tag, "_pix_idx"}, ifa.pix_idx, 0);
      chk({tag, "_err_len"}, ifa.err_len, 0);
      chk({tag, "_err_sync"}, ifa.err_sync, 0);
   endtask

   initial begin
      #12;
      check_zero("reset");
      @(posedge pclk);
      #1 rst_n = 1'b1;
      idle(3, 0);

      // good frame with din = pixel + line + 1
      do_start();
      cnt_ha = 0; cnt_hb = 0; sum_b = 0; cnt_fd = 0;
      do_arm();
      for (int l = 0; l < V; l++) do_line(H, 0, 0, 1);
      idle(2, 0);
      chk("lit_href_a_cycles", cnt_ha, 1230);
      chk("lit_href_b_cycles", cnt_hb, 4);
      chk("lit_din_b_sum", sum_b, 54);
      chk("lit_frame_done_pulses", cnt_fd, 1);

      // short line 1
      do_start();
      cnt_fd = 0;
      do_arm();
      do_line(H, 0, 0, 1);
      do_line(H - 1, 0, 0, 1);
      do_line(H, 0, 0, 1);
      idle(2, 0);
      chk("lit_short_no_done", cnt_fd, 0);
      chk("lit_short_err_len", ifa.err_len, 1);

      // vsync rises where line 2 is cut short, then three good lines
      do_start();
      do_arm();
      do_line(H, 0, 0, 0);
      do_line(H, 0, 0, 0);
      do_line(H, 200, 1, 0);
      for (int l = 0; l < V; l++) do_line(H, 0, 0, 0);
      idle(2, 0);
      chk("lit_glitch_no_done", cnt_fd, 0);

      // abort mid-line 1 (line 0 short so err_len is held), then clean frame
      do_start();
      do_arm();
      do_line(H - 1, 0, 0, 0);
      do_line(H, 100, 2, 0);
      idle(2, 0);
      chk("lit_abort_err_held", ifa.err_len, 1);
      do_start();
      do_arm();
      for (int l = 0; l < V; l++) do_line(H, 0, 0, 0);
      idle(2, 0);
      chk("lit_after_abort_done", cnt_fd, 1);

      // randomized frames, occasional wrong line lengths and stray starts
      for (int f = 0; f < 4; f++) begin
         do_start();
         idle($urandom_range(0, 3), 1);
         do_arm();
         for (int l = 0; l < V; l++)
            do_line(($urandom_range(0, 3) == 0) ? int'($urandom_range(H - 3, H + 3)) : H, 0, 0, 0);
         idle($urandom_range(1, 4), 0);
      end

      // asynchronous reset in the middle of a line
      do_start();
      do_arm();
      idle(1, 0);
      for (int c = 0; c < 50; c++) step(0, 1, 0, 0, 8'($urandom), 1, 0, c + 1);
      chk_en = 0;
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      href = 0;
      m_busy = 0; m_el = 0; m_es = 0; m_fd = 0; m_cap = 0; m_row = 0;
      @(posedge pclk);
      #1 rst_n = 1'b1;
      idle(2, 0);
      do_start();
      for (int i = 0; i < 6; i++) step(0, i[0], 0, 0, 8'($urandom), 0, 0, -1);
      chk("lit_arm_busy", ifa.busy, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
